// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared types and default constants for the memory port arbiter.
//   owner_t        : tag carried down the owner pipeline to route read data back
//   MEM_LAT_DEF    : default memory read latency (cycles from issue to rdata)
//   STARVE_MAX_DEF : default number of consecutive IF losses before IF is forced
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_t;

  localparam int MEM_LAT_DEF    = 2;
  localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: all handshake/bus signals around the arbiter.
//   IF side  : if_req/if_addr in, if_ready/if_rvalid/if_rdata out
//   DM side  : dm_req/dm_we/dm_addr/dm_wdata in, dm_ready/dm_rvalid/dm_rdata out
//   Mem side : mem_en/mem_we/mem_addr/mem_wdata out, mem_rdata in
// Modports: slave = the arbiter, master = requesters plus memory.
interface mem_port_arbiter_if #(
  parameter int Bits  = 64,
  parameter int AddrW = 4
);
  logic             if_req;
  logic [AddrW-1:0] if_addr;
  logic             if_ready;
  logic             if_rvalid;
  logic [Bits-1:0]  if_rdata;

  logic             dm_req;
  logic             dm_we;
  logic [AddrW-1:0] dm_addr;
  logic [Bits-1:0]  dm_wdata;
  logic             dm_ready;
  logic             dm_rvalid;
  logic [Bits-1:0]  dm_rdata;

  logic             mem_en;
  logic             mem_we;
  logic [AddrW-1:0] mem_addr;
  logic [Bits-1:0]  mem_wdata;
  logic [Bits-1:0]  mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_ready, if_rvalid, if_rdata, dm_ready, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_ready, if_rvalid, if_rdata, dm_ready, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter_owner_pipe.sv
// arb_owner_pipe: MemLat-deep shift register of owner tags. Stage 0 is loaded
// at issue; the last stage lines up with mem_rdata for that access.
//   clk, rst : clock, synchronous active-high reset (flushes to OWN_NONE)
//   own_in   : owner of the access issued this cycle
//   own_out  : owner of the read whose data is on mem_rdata now
module arb_owner_pipe
  import mem_arb_pkg::*;
#(
  parameter int MemLat = MEM_LAT_DEF
) (
  input  logic   clk,
  input  logic   rst,
  input  owner_t own_in,
  output owner_t own_out
);

  owner_t own_pipe [MemLat];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MemLat; i++) own_pipe[i] <= OWN_NONE;
    end else begin
      own_pipe[0] <= own_in;
      for (int i = 1; i < MemLat; i++) own_pipe[i] <= own_pipe[i-1];
    end
  end

  assign own_out = own_pipe[MemLat-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch (IF) and
// the data stage (DM). One access per cycle; DM normally wins, but after
// StarveMax consecutive IF losses IF is forced through. Read data is steered
// back to its owner MemLat cycles after issue via a tag pipeline.
//   clk, rst : clock, synchronous active-high reset
//   bus      : IF, DM and memory signals (see mem_port_arbiter_if)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int Bits      = 64,
  parameter int MemSize   = 16,
  parameter int AddrW     = $clog2(MemSize),
  parameter int MemLat    = MEM_LAT_DEF,
  parameter int StarveMax = STARVE_MAX_DEF
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam int CntW = $clog2(StarveMax + 1);

  logic [CntW-1:0]  starve_cnt;
  logic             starved;
  logic             grant_if, grant_dm;
  logic [AddrW-1:0] addr_sel;
  logic [Bits-1:0]  wdata_sel;
  owner_t           own_in, own_out;

  assign starved  = (starve_cnt == CntW'(StarveMax));
  assign grant_if = !rst && bus.if_req && (!bus.dm_req || starved);
  assign grant_dm = !rst && bus.dm_req && !grant_if;

  // Counts consecutive lost cycles; any gap in if_req restarts the count.
  always_ff @(posedge clk) begin
    if (rst)                           starve_cnt <= '0;
    else if (!bus.if_req || grant_if)  starve_cnt <= '0;
    else if (!starved)                 starve_cnt <= starve_cnt + 1'b1;
  end

  always_comb begin
    addr_sel  = '0;
    wdata_sel = '0;
    if (grant_if) begin
      addr_sel = bus.if_addr;
    end else if (grant_dm) begin
      addr_sel  = bus.dm_addr;
      wdata_sel = bus.dm_wdata;
    end
  end

  assign bus.if_ready  = grant_if;
  assign bus.dm_ready  = grant_dm;
  assign bus.mem_en    = grant_if | grant_dm;
  assign bus.mem_we    = grant_dm & bus.dm_we;
  assign bus.mem_addr  = addr_sel;
  assign bus.mem_wdata = wdata_sel;

  // Writes get no tag: they complete at grant and never return data.
  assign own_in = grant_if                 ? OWN_IF :
                  (grant_dm && !bus.dm_we) ? OWN_DM : OWN_NONE;

  arb_owner_pipe #(.MemLat(MemLat)) u_owner_pipe (
    .clk     (clk),
    .rst     (rst),
    .own_in  (own_in),
    .own_out (own_out)
  );

  // Gate on rst as well: the pipe only flushes at the edge, but outputs must
  // already read zero during the reset cycle.
  assign bus.if_rvalid = !rst && (own_out == OWN_IF);
  assign bus.dm_rvalid = !rst && (own_out == OWN_DM);
  assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;
  assign bus.dm_rdata  = bus.dm_rvalid ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int Bits = 64, MemSize = 16, AddrW = 4, Lat = 2, SMax = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.Bits(Bits), .AddrW(AddrW)) bus();

  mem_port_arbiter #(
    .Bits(Bits), .MemSize(MemSize), .AddrW(AddrW), .MemLat(Lat), .StarveMax(SMax)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [63:0] init_val(int i);
    return 64'h5A00 + 64'(i);
  endfunction

  // Environment RAM driven by the DUT's mem_* outputs; idle return slots carry noise.
  logic [63:0] ram     [MemSize];
  logic [63:0] rd_pipe [Lat];
  bit          ram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < MemSize; i++) ram[i] <= init_val(i);
      ram_loaded <= 1'b1;
    end else if (bus.mem_en && bus.mem_we) begin
      ram[bus.mem_addr] <= bus.mem_wdata;
    end
    rd_pipe[0] <= (bus.mem_en && !bus.mem_we) ? ram[bus.mem_addr] : {$urandom, $urandom};
    for (int i = 1; i < Lat; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.mem_rdata = rd_pipe[Lat-1];

  typedef struct {
    logic        rst, ir;
    logic [3:0]  ia;
    logic        dr, dw;
    logic [3:0]  da;
    logic [63:0] dwd;
    logic        e_ir, e_dr, e_iv, e_dv;
    logic [63:0] e_rd;
  } vec_t;

  typedef struct {
    int          due;
    owner_t      own;
    logic [63:0] d;
  } ret_t;

  // Reference model: expected memory contents, pending returns, loss count.
  logic [63:0] ref_ram [MemSize];
  ret_t        rq [$];
  int          losses = 0;
  int          cyc = 0;
  int          checks = 0, errors = 0;
  vec_t        tv [$];

  function automatic vec_t mk(logic r, logic ir, int ia, logic dr, logic dw, int da,
                              logic [63:0] dwd, logic e_ir, logic e_dr, logic e_iv,
                              logic e_dv, logic [63:0] e_rd);
    vec_t v;
    v.rst = r; v.ir = ir; v.ia = 4'(ia); v.dr = dr; v.dw = dw; v.da = 4'(da);
    v.dwd = dwd; v.e_ir = e_ir; v.e_dr = e_dr; v.e_iv = e_iv; v.e_dv = e_dv;
    v.e_rd = e_rd;
    return v;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  // One cycle: drive (just after posedge), check at negedge, advance model at posedge.
  task automatic step(input vec_t v, input bit tbl, output bit gi, output bit gd);
    bit          iv, dv;
    logic [63:0] rd;
    rst = v.rst;
    bus.if_req = v.ir; bus.if_addr = v.ia;
    bus.dm_req = v.dr; bus.dm_we = v.dw; bus.dm_addr = v.da; bus.dm_wdata = v.dwd;
    @(negedge clk);
    gi = !v.rst && v.ir && (!v.dr || losses >= SMax);
    gd = !v.rst && v.dr && !gi;
    iv = 1'b0; dv = 1'b0; rd = '0;
    if (!v.rst && rq.size() > 0 && rq[0].due == cyc) begin
      iv = (rq[0].own == OWN_IF);
      dv = (rq[0].own == OWN_DM);
      rd = rq[0].d;
    end
    chk("if_ready",   64'(bus.if_ready),  64'(gi));
    chk("dm_ready",   64'(bus.dm_ready),  64'(gd));
    chk("mem_en",     64'(bus.mem_en),    64'(gi | gd));
    chk("mem_we",     64'(bus.mem_we),    64'(gd & v.dw));
    chk("mem_addr",   64'(bus.mem_addr),  gi ? 64'(v.ia) : gd ? 64'(v.da) : 64'd0);
    chk("mem_wdata",  bus.mem_wdata,      gd ? v.dwd : 64'd0);
    chk("if_rvalid",  64'(bus.if_rvalid), 64'(iv));
    chk("dm_rvalid",  64'(bus.dm_rvalid), 64'(dv));
    chk("if_rdata",   bus.if_rdata,       iv ? rd : 64'd0);
    chk("dm_rdata",   bus.dm_rdata,       dv ? rd : 64'd0);
    chk("starve_cnt", 64'(dut.starve_cnt), 64'(losses));
    if (tbl) begin
      chk("tbl_if_ready",  64'(bus.if_ready),  64'(v.e_ir));
      chk("tbl_dm_ready",  64'(bus.dm_ready),  64'(v.e_dr));
      chk("tbl_if_rvalid", 64'(bus.if_rvalid), 64'(v.e_iv));
      chk("tbl_dm_rvalid", 64'(bus.dm_rvalid), 64'(v.e_dv));
      chk("tbl_rdata",     bus.if_rdata | bus.dm_rdata, v.e_rd);
    end
    @(posedge clk);
    if (rq.size() > 0 && rq[0].due <= cyc) void'(rq.pop_front());
    if (v.rst) begin
      rq.delete();
      losses = 0;
    end else begin
      if (gi)           rq.push_back('{cyc + Lat, OWN_IF, ref_ram[v.ia]});
      if (gd && !v.dw)  rq.push_back('{cyc + Lat, OWN_DM, ref_ram[v.da]});
      if (gd && v.dw)   ref_ram[v.da] = v.dwd;
      losses = (v.ir && !gi) ? ((losses < SMax) ? losses + 1 : SMax) : 0;
    end
    cyc++;
    #1;
  endtask

  initial begin
    vec_t        v;
    bit          gi, gd;
    bit          ip, dp;
    logic [63:0] z;
    z = 64'd0;
    rst = 1'b1;
    bus.if_req = 1'b1; bus.if_addr = '0;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
    for (int i = 0; i < MemSize; i++) ref_ram[i] = init_val(i);

    //          rst ir ia dr dw da dwd      eir edr eiv edv e_rd
    // reset with both requesting
    tv.push_back(mk(1, 1, 0, 1, 0, 0, z,     0, 0, 0, 0, z));
    tv.push_back(mk(1, 1, 0, 1, 0, 0, z,     0, 0, 0, 0, z));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, z,     0, 0, 0, 0, z));
    // IF-only read of addr 3
    tv.push_back(mk(0, 1, 3, 0, 0, 0, z,     1, 0, 0, 0, z));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, z,     0, 0, 0, 0, z));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, z,     0, 0, 1, 0, 64'h5A03));
    // contention: DM wins, IF next cycle, returns in order
    tv.push_back(mk(0, 1, 2, 1, 0, 5, z,     0, 1, 0, 0, z));
    tv.push_back(mk(0, 1, 2, 0, 0, 0, z,     1, 0, 0, 0, z));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, z,     0, 0, 0, 1, 64'h5A05));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, z,     0, 0, 1, 0, 64'h5A02));
    // starvation: DM held, IF loses four times then is forced through
    tv.push_back(mk(0, 1, 4, 1, 0, 1, z,     0, 1, 0, 0, z));
    tv.push_back(mk(0, 1, 4, 1, 0, 1, z,     0, 1, 0, 0, z));
    tv.push_back(mk(0, 1, 4, 1, 0, 1, z,     0, 1, 0, 1, 64'h5A01));
    tv.push_back(mk(0, 1, 4, 1, 0, 1, z,     0, 1, 0, 1, 64'h5A01));
    tv.push_back(mk(0, 1, 4, 1, 0, 1, z,     1, 0, 0, 1, 64'h5A01));
    tv.push_back(mk(0, 0, 0, 1, 0, 1, z,     0, 1, 0, 1, 64'h5A01));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, z,     0, 0, 1, 0, 64'h5A04));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, z,     0, 0, 0, 1, 64'h5A01));
    // pipelining: two IF reads, DM write, then read back the write
    tv.push_back(mk(0, 1, 0, 0, 0, 0, z,     1, 0, 0, 0, z));
    tv.push_back(mk(0, 1, 1, 0, 0, 0, z,     1, 0, 0, 0, z));
    tv.push_back(mk(0, 0, 0, 1, 1, 7, 64'hAA, 0, 1, 1, 0, 64'h5A00));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, z,     0, 0, 1, 0, 64'h5A01));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, z,     0, 0, 0, 0, z));
    tv.push_back(mk(0, 0, 0, 1, 0, 7, z,     0, 1, 0, 0, z));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, z,     0, 0, 0, 0, z));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, z,     0, 0, 0, 1, 64'hAA));
    // reset while an IF read is in flight: its return is dropped
    tv.push_back(mk(0, 1, 3, 0, 0, 0, z,     1, 0, 0, 0, z));
    tv.push_back(mk(1, 0, 0, 0, 0, 0, z,     0, 0, 0, 0, z));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, z,     0, 0, 0, 0, z));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, z,     0, 0, 0, 0, z));

    @(posedge clk);
    #1;
    foreach (tv[i]) step(tv[i], 1'b1, gi, gd);

    // Random traffic; a requester holds its request until granted.
    v = mk(0, 0, 0, 0, 0, 0, z, 0, 0, 0, 0, z);
    ip = 1'b0; dp = 1'b0;
    for (int n = 0; n < 600; n++) begin
      v.rst = ($urandom_range(0, 79) == 0);
      if (!ip) begin
        v.ir = ($urandom_range(0, 9) < 6);
        v.ia = 4'($urandom_range(0, MemSize - 1));
      end
      if (!dp) begin
        v.dr  = ($urandom_range(0, 9) < 8);
        v.dw  = ($urandom_range(0, 9) < 3);
        v.da  = 4'($urandom_range(0, MemSize - 1));
        v.dwd = {$urandom, $urandom};
      end
      step(v, 1'b0, gi, gd);
      ip = v.ir && !gi && !v.rst;
      dp = v.dr && !gd && !v.rst;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
